// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and shared-memory-port signals around mem_port_arbiter.
// The master side is the pipeline plus the L1 port; the slave side is the arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              i_en;
    logic              i_wren;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_wdata;
    logic [DATA_W-1:0] i_rdata;
    logic              i_done;
    logic              i_busy;

    logic              d_en;
    logic              d_wren;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;
    logic              d_busy;

    logic              mem_en;
    logic              mem_wren;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_done;

    logic              owner;
    logic              proto_err;

    modport master (
        output i_en, i_wren, i_addr, i_wdata,
        output d_en, d_wren, d_addr, d_wdata,
        output mem_rdata, mem_done,
        input  i_rdata, i_done, i_busy,
        input  d_rdata, d_done, d_busy,
        input  mem_en, mem_wren, mem_addr, mem_wdata,
        input  owner, proto_err
    );

    modport slave (
        input  i_en, i_wren, i_addr, i_wdata,
        input  d_en, d_wren, d_addr, d_wdata,
        input  mem_rdata, mem_done,
        output i_rdata, i_done, i_busy,
        output d_rdata, d_done, d_busy,
        output mem_en, mem_wren, mem_addr, mem_wdata,
        output owner, proto_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one L1 port between instruction fetch and the Mem stage, one transaction at a time.
// Define MEM_ARB_RR_EN for round-robin tie breaking; otherwise data always wins ties.
module mem_port_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic {IDLE, WAIT} state_t;

    typedef struct packed {
        logic              wren;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    state_t            state;
    logic              i_pend_v, d_pend_v;
    req_t              i_pend, d_pend;
    req_t              i_req_in, d_req_in;
    logic              i_take, d_take;
    logic              i_cand, d_cand;
    logic              grant_d;
    req_t              grant_req;

    logic              mem_en, mem_wren, owner, proto_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] i_rdata, d_rdata;
    logic              i_done, d_done;
`ifdef MEM_ARB_RR_EN
    logic              last_grant;
`endif

    assign i_req_in = '{wren: bus.i_wren, addr: bus.i_addr, wdata: bus.i_wdata};
    assign d_req_in = '{wren: bus.d_wren, addr: bus.d_addr, wdata: bus.d_wdata};

    // A slot stays valid until its transaction completes, so it alone defines busy.
    assign i_take = bus.i_en && !i_pend_v;
    assign d_take = bus.d_en && !d_pend_v;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        i_cand    = i_pend_v || i_take;
        d_cand    = d_pend_v || d_take;
`ifdef MEM_ARB_RR_EN
        grant_d   = (i_cand && d_cand) ? !last_grant : d_cand;
`else
        grant_d   = d_cand;
`endif
        grant_req = grant_d ? (d_pend_v ? d_pend : d_req_in)
                            : (i_pend_v ? i_pend : i_req_in);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            i_pend_v  <= 1'b0;
            d_pend_v  <= 1'b0;
            mem_en    <= 1'b0;
            mem_wren  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            owner     <= 1'b0;
            proto_err <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_grant <= 1'b1;
`endif
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            if ((bus.i_en && i_pend_v) || (bus.d_en && d_pend_v))
                proto_err <= 1'b1;
            if (i_take) i_pend_v <= 1'b1;
            if (d_take) d_pend_v <= 1'b1;

            case (state)
                IDLE: begin
                    if (i_cand || d_cand) begin
                        mem_en    <= 1'b1;
                        mem_wren  <= grant_req.wren;
                        mem_addr  <= grant_req.addr;
                        mem_wdata <= grant_req.wdata;
                        owner     <= grant_d;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    mem_en   <= 1'b0;
                    mem_wren <= 1'b0;
                    if (bus.mem_done) begin
                        if (owner) begin
                            d_rdata  <= bus.mem_rdata;
                            d_done   <= 1'b1;
                            d_pend_v <= 1'b0;
                        end else begin
                            i_rdata  <= bus.mem_rdata;
                            i_done   <= 1'b1;
                            i_pend_v <= 1'b0;
                        end
`ifdef MEM_ARB_RR_EN
                        last_grant <= owner;
`endif
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: slot payloads are qualified by their valid bits, so they need no reset.
    always_ff @(posedge clk) begin
        if (i_take) i_pend <= i_req_in;
        if (d_take) d_pend <= d_req_in;
    end

    assign bus.mem_en    = mem_en;
    assign bus.mem_wren  = mem_wren;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.owner     = owner;
    assign bus.proto_err = proto_err;
    assign bus.i_rdata   = i_rdata;
    assign bus.d_rdata   = d_rdata;
    assign bus.i_done    = i_done;
    assign bus.d_done    = d_done;
    assign bus.i_busy    = i_pend_v;
    assign bus.d_busy    = d_pend_v;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: tie break, read/write timing, protocol error,
// stray completion and reset during a transaction.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

`ifdef MEM_ARB_RR_EN
    localparam logic        FIRST_OWNER = 1'b0;
    localparam logic [63:0] FIRST_ADDR  = 64'h10;
    localparam logic [63:0] SECOND_ADDR = 64'h20;
`else
    localparam logic        FIRST_OWNER = 1'b1;
    localparam logic [63:0] FIRST_ADDR  = 64'h20;
    localparam logic [63:0] SECOND_ADDR = 64'h10;
`endif

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.i_en = 1'b0;
        bus.d_en = 1'b0;
        bus.mem_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        bus.i_wren = 1'b0;  bus.i_addr = '0;  bus.i_wdata = '0;
        bus.d_wren = 1'b0;  bus.d_addr = '0;  bus.d_wdata = '0;
        bus.mem_rdata = '0;
        quiet();

        // Reset state
        repeat (3) tick();
        check("rst mem_en", bus.mem_en, 0);
        check("rst mem_addr", bus.mem_addr, 0);
        check("rst owner", bus.owner, 0);
        check("rst proto_err", bus.proto_err, 0);
        check("rst i_busy", bus.i_busy, 0);
        check("rst d_busy", bus.d_busy, 0);
        check("rst d_rdata", bus.d_rdata, 0);
        reset_n = 1'b1;
        tick();

        // Simultaneous requests: tie break, zero-wait port, one idle cycle between
        bus.i_en = 1'b1;  bus.i_addr = 64'h10;
        bus.d_en = 1'b1;  bus.d_addr = 64'h20;
        tick();
        quiet();
        check("tie c1 mem_en", bus.mem_en, 1);
        check("tie c1 mem_addr", bus.mem_addr, FIRST_ADDR);
        check("tie c1 owner", bus.owner, FIRST_OWNER);
        check("tie c1 i_busy", bus.i_busy, 1);
        check("tie c1 d_busy", bus.d_busy, 1);
        bus.mem_done = 1'b1;  bus.mem_rdata = 64'h1111;
        tick();
        quiet();
        check("tie c2 mem_en", bus.mem_en, 0);
        check("tie c2 d_done", bus.d_done, FIRST_OWNER);
        check("tie c2 i_done", bus.i_done, !FIRST_OWNER);
        tick();
        check("tie c3 mem_en", bus.mem_en, 1);
        check("tie c3 mem_addr", bus.mem_addr, SECOND_ADDR);
        check("tie c3 owner", bus.owner, !FIRST_OWNER);
        tick();
        check("tie c4 mem_en", bus.mem_en, 0);
        bus.mem_done = 1'b1;  bus.mem_rdata = 64'h2222;
        tick();
        quiet();
        check("tie c5 d_done", bus.d_done, !FIRST_OWNER);
        check("tie c5 i_done", bus.i_done, FIRST_OWNER);
        check("tie c5 i_rdata", bus.i_rdata, FIRST_OWNER ? 64'h2222 : 64'h1111);
        check("tie c5 d_rdata", bus.d_rdata, FIRST_OWNER ? 64'h1111 : 64'h2222);
        check("tie c5 i_busy", bus.i_busy, 0);
        check("tie c5 d_busy", bus.d_busy, 0);

        // Single data read, completion in cycle 4
        bus.d_en = 1'b1;  bus.d_wren = 1'b0;  bus.d_addr = 64'h1000;
        tick();
        quiet();
        check("rd c1 mem_en", bus.mem_en, 1);
        check("rd c1 mem_addr", bus.mem_addr, 64'h1000);
        check("rd c1 mem_wren", bus.mem_wren, 0);
        check("rd c1 owner", bus.owner, 1);
        tick();
        check("rd c2 mem_en", bus.mem_en, 0);
        check("rd c2 mem_addr", bus.mem_addr, 64'h1000);
        check("rd c2 d_busy", bus.d_busy, 1);
        tick();
        tick();
        bus.mem_done = 1'b1;  bus.mem_rdata = 64'hDEADBEEF;
        tick();
        quiet();
        check("rd c5 d_done", bus.d_done, 1);
        check("rd c5 d_rdata", bus.d_rdata, 64'hDEADBEEF);
        check("rd c5 d_busy", bus.d_busy, 0);
        check("rd c5 i_done", bus.i_done, 0);
        tick();
        check("rd c6 d_done", bus.d_done, 0);
        check("rd c6 mem_en", bus.mem_en, 0);

        // Fetch-side write
        bus.i_en = 1'b1;  bus.i_wren = 1'b1;  bus.i_addr = 64'h2000;  bus.i_wdata = 64'h55;
        tick();
        quiet();
        bus.i_wren = 1'b0;
        check("wr c1 mem_wren", bus.mem_wren, 1);
        check("wr c1 mem_wdata", bus.mem_wdata, 64'h55);
        check("wr c1 owner", bus.owner, 0);
        check("wr c1 i_busy", bus.i_busy, 1);
        tick();
        check("wr c2 mem_wren", bus.mem_wren, 0);
        check("wr c2 mem_wdata", bus.mem_wdata, 64'h55);
        bus.mem_done = 1'b1;  bus.mem_rdata = 64'h77;
        tick();
        quiet();
        check("wr c3 i_done", bus.i_done, 1);
        check("wr c3 i_rdata", bus.i_rdata, 64'h77);
        check("wr c3 i_busy", bus.i_busy, 0);
        tick();

        // Protocol error, then a new request in the done cycle
        bus.d_en = 1'b1;  bus.d_addr = 64'h3000;
        tick();
        bus.d_addr = 64'h4000;
        check("pe c1 mem_en", bus.mem_en, 1);
        tick();
        quiet();
        check("pe c2 proto_err", bus.proto_err, 1);
        check("pe c2 mem_en", bus.mem_en, 0);
        bus.mem_done = 1'b1;  bus.mem_rdata = 64'h33;
        tick();
        quiet();
        check("pe c3 d_done", bus.d_done, 1);
        check("pe c3 mem_addr", bus.mem_addr, 64'h3000);
        check("pe c3 d_busy", bus.d_busy, 0);
        bus.d_en = 1'b1;  bus.d_addr = 64'h5000;
        tick();
        quiet();
        check("pe c4 mem_en", bus.mem_en, 1);
        check("pe c4 mem_addr", bus.mem_addr, 64'h5000);
        check("pe c4 d_busy", bus.d_busy, 1);
        bus.mem_done = 1'b1;  bus.mem_rdata = 64'h50;
        tick();
        quiet();
        check("pe c5 d_done", bus.d_done, 1);
        check("pe c5 proto_err", bus.proto_err, 1);

        // Stray completion in IDLE
        tick();
        bus.mem_done = 1'b1;  bus.mem_rdata = 64'h99;
        tick();
        quiet();
        check("stray i_done", bus.i_done, 0);
        check("stray d_done", bus.d_done, 0);
        check("stray mem_en", bus.mem_en, 0);
        check("stray d_rdata", bus.d_rdata, 64'h50);
        tick();
        check("stray later mem_en", bus.mem_en, 0);

        // Reset during WAIT
        bus.i_en = 1'b1;  bus.i_addr = 64'h6000;
        tick();
        quiet();
        check("mr c1 mem_en", bus.mem_en, 1);
        tick();
        reset_n = 1'b0;
        #1;
        check("mr mem_addr", bus.mem_addr, 0);
        check("mr i_busy", bus.i_busy, 0);
        check("mr proto_err", bus.proto_err, 0);
        check("mr i_rdata", bus.i_rdata, 0);
        tick();
        reset_n = 1'b1;
        tick();
        bus.mem_done = 1'b1;  bus.mem_rdata = 64'hAA;
        tick();
        quiet();
        check("mr late i_done", bus.i_done, 0);
        check("mr late mem_en", bus.mem_en, 0);
        tick();
        check("mr late2 i_done", bus.i_done, 0);
        check("mr late2 i_rdata", bus.i_rdata, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one cache/memory port (en/wren/addr/wdata/rdata/done protocol) between the instruction-fetch requester and the Mem-stage data requester. It latches single-cycle request pulses and selects one requester per transaction. It issues a one-cycle en pulse downstream, waits for done, and returns rdata and a done pulse to the owner. It sits between the pipeline front end / Mem stage and the shared L1 port.

Parameters:
ADDR_W, 64, address width of all ports
DATA_W, 64, read/write data width of all ports

Ports:
clk  in  1  clock, all state updates on rising edge
reset_n  in  1  asynchronous, active-low reset
i_en  in  1  fetch request pulse (one cycle)
i_wren  in  1  fetch write flag (normally 0), sampled with i_en
i_addr  in  ADDR_W  fetch address, sampled with i_en
i_wdata  in  DATA_W  fetch write data, sampled with i_en
i_rdata  out  DATA_W  read data for fetch, valid with i_done
i_done  out  1  one-cycle completion pulse to fetch
i_busy  out  1  fetch request pending or in service
d_en  in  1  data request pulse (one cycle)
d_wren  in  1  data write flag, sampled with d_en
d_addr  in  ADDR_W  data address, sampled with d_en
d_wdata  in  DATA_W  data write data, sampled with d_en
d_rdata  out  DATA_W  read data for Mem stage, valid with d_done
d_done  out  1  one-cycle completion pulse to Mem stage
d_busy  out  1  data request pending or in service
mem_en  out  1  one-cycle request pulse to shared port
mem_wren  out  1  write flag, valid with mem_en, cleared with it
mem_addr  out  ADDR_W  address, held stable until mem_done
mem_wdata  out  DATA_W  write data, held stable until mem_done
mem_rdata  in  DATA_W  read data, valid with mem_done
mem_done  in  1  completion from shared port
owner  out  1  current/last grant: 0 = fetch, 1 = data
proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (async assert, sync release): state IDLE, both pending slots cleared. All outputs 0, including rdata buses, owner and proto_err; last_grant = 1.
- Each requester has one pending slot: valid, wren, addr, wdata. A request is captured on the edge where x_en = 1.
- x_busy = pending valid OR (state != IDLE AND owner == x), registered.
- A new x_en while x_busy = 1 is dropped and sets proto_err. proto_err is cleared only by reset.
- States:
  - IDLE: candidates = pending valid OR x_en this cycle (same-edge bypass). If any candidate exists, pick the winner and register mem_en = 1, mem_wren, mem_addr, mem_wdata and owner. Clear nothing yet; go to WAIT. The loser's x_en is captured into its slot.
  - WAIT: mem_en = 0 and mem_wren = 0 from the second cycle on; mem_addr/mem_wdata held. On mem_done: x_rdata <= mem_rdata (write ops also copy mem_rdata), x_done <= 1 for one cycle, clear the owner's pending slot, last_grant <= owner, go to IDLE.
- mem_done in IDLE is ignored (no done pulse, no state change).
- Latency: x_en at cycle 0 with port idle gives mem_en in cycle 1. mem_done in cycle k gives x_done in cycle k+1, and the next mem_en earliest in cycle k+2 (one idle cycle between transactions).
- mem_done in the same cycle mem_en is high completes the transaction (zero-wait port is legal).
- Fixed priority (macro absent): data wins over fetch when both are candidates.
- A requester may issue its next x_en in the cycle x_done is high; it is accepted because busy has already cleared.
- Reset mid-transaction abandons the transaction; no done pulse is produced and a late mem_done after reset is ignored.

Optional Feature:
MEM_ARB_RR_EN: when defined, ties are broken round-robin: the requester that is not last_grant wins. With last_grant reset to 1, fetch wins the first tie. When undefined, data always wins ties and fetch can starve while the data side keeps requesting.

Test Plan:
- Single read: d_en with d_addr=0x1000, d_wren=0 at cycle 0 -> mem_en=1 and mem_addr=0x1000 at cycle 1. With mem_done and mem_rdata=0xDEADBEEF at cycle 4 -> d_done=1, d_rdata=0xDEADBEEF at cycle 5, d_busy=0 at cycle 5.
- Write: i_en, i_wren=1, i_addr=0x2000, i_wdata=0x55 -> mem_wren=1 and mem_wdata=0x55 in cycle 1. mem_wdata is held until mem_done, then i_done pulses.
- Simultaneous i_en and d_en at cycle 0 (addr 0x10 / 0x20) -> 0x20 is issued first and 0x10 is issued 2 cycles after the first mem_done. With MEM_ARB_RR_EN, 0x10 is issued first instead.
- Protocol error: second d_en while d_busy=1 -> request dropped, only one mem_en, proto_err=1 and held until reset.
- Stray mem_done in IDLE -> no i_done/d_done pulse, state unchanged.
- reset_n low during WAIT -> all outputs 0 immediately. A later mem_done is ignored and no done pulse occurs.
